// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared types and helpers for the sequential radix-2 Booth multiplier.
//   state_t     : controller states (IDLE, RUN, DONE)
//   BOOTH_*     : codes for the examined bit pair {Q[0], q_1}
//   cnt_width() : width of the iteration counter for a given operand width
// -----------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // {Q[0], q_1}: 01 -> add multiplicand, 10 -> subtract, 00/11 -> no add
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // The counter must hold WIDTH+1 (the iteration count).
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// -----------------------------------------------------------------------------
// booth_step
// One combinational radix-2 Booth iteration on an N-bit multiplier.
//   a_in  [N:0]   : accumulator (one guard bit above N, never overflows)
//   q_in  [N-1:0] : multiplier / low product bits
//   q1_in         : bit shifted out of Q on the previous step
//   m     [N:0]   : sign-extended multiplicand
//   a_out, q_out, q1_out : state after add/sub and arithmetic shift right
// -----------------------------------------------------------------------------
module booth_step
  import booth_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N:0]   a_in,
  input  logic [N-1:0] q_in,
  input  logic         q1_in,
  input  logic [N:0]   m,
  output logic [N:0]   a_out,
  output logic [N-1:0] q_out,
  output logic         q1_out
);

  logic [N:0] sum;

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise an unlisted case infers a latch.
  always_comb begin
    sum = a_in;
    case ({q_in[0], q1_in})
      BOOTH_ADD: sum = a_in + m;
      BOOTH_SUB: sum = a_in - m;
      default:   sum = a_in;
    endcase
  end

  // Arithmetic shift right of {A, Q, q_1}: the accumulator MSB is replicated
  // and the old q_1 falls off the end.
  assign {a_out, q_out, q1_out} = {sum[N], sum, q_in};

endmodule

// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
// Multi-cycle radix-2 Booth multiplier, one Booth step per clock.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : request, accepted only while idle
//   is_signed    : 1 = two's-complement operands, 0 = unsigned
//   a, b         : multiplicand / multiplier, captured with start
//   busy         : high while iterating
//   done         : one-cycle pulse when c is updated
//   c            : 2*WIDTH-bit product register, held between operations
// Operands are extended to WIDTH+1 bits (sign or zero) so both modes share
// the same signed datapath; WIDTH+1 iterations are always performed.
// -----------------------------------------------------------------------------
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);

  localparam int N  = WIDTH + 1;
  localparam int CW = cnt_width(WIDTH);

  state_t          state_q, state_n;
  logic [N:0]      m_q, a_q, a_nxt;
  logic [N-1:0]    q_q, q_nxt;
  logic            q1_q, q1_nxt;
  logic [CW-1:0]   cnt_q;
  logic [2*WIDTH-1:0] c_q;
  logic            done_q;

  logic [N:0]      a_ext;
  logic [N-1:0]    b_ext;

  // The extension bit of each operand is its MSB only in signed mode; the
  // multiplicand gets one extra copy to fill the accumulator guard bit.
  assign a_ext = {{2{is_signed & a[WIDTH-1]}}, a};
  assign b_ext = {is_signed & b[WIDTH-1], b};

  booth_step #(.N(N)) u_step (
    .a_in   (a_q),
    .q_in   (q_q),
    .q1_in  (q1_q),
    .m      (m_q),
    .a_out  (a_nxt),
    .q_out  (q_nxt),
    .q1_out (q1_nxt)
  );

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (cnt_q == CW'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN);
  end

  // Datapath, counter and result register
  // NOTE: all working registers are reset too, so an aborted operation leaves
  // no stale partial product behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= '0;
      a_q    <= '0;
      q_q    <= '0;
      q1_q   <= 1'b0;
      cnt_q  <= '0;
      c_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q   <= a_ext;
            a_q   <= '0;
            q_q   <= b_ext;
            q1_q  <= 1'b0;
            cnt_q <= CW'(N);
          end
        end
        RUN: begin
          a_q   <= a_nxt;
          q_q   <= q_nxt;
          q1_q  <= q1_nxt;
          cnt_q <= cnt_q - CW'(1);
        end
        DONE: begin
          // Low 2*WIDTH bits of {A, Q}: Q supplies WIDTH+1, A the rest.
          c_q    <= {a_q[WIDTH-2:0], q_q};
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign c    = c_q;
  assign done = done_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
// Drives a WIDTH=8 and a WIDTH=16 instance of booth_mult_seq and compares
// products, latency and busy duration against plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start8, sg8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;

  logic        start16, sg16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] c16;

  int n_cmp = 0;
  int n_err = 0;

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start8),
    .is_signed (sg8),
    .a         (a8),
    .b         (b8),
    .busy      (busy8),
    .done      (done8),
    .c         (c8)
  );

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start16),
    .is_signed (sg16),
    .a         (a16),
    .b         (b16),
    .busy      (busy16),
    .done      (done16),
    .c         (c16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product: interpret operands as integers and multiply.
  function automatic logic [31:0] model(input bit wide, input bit sgn,
                                        input logic [15:0] av, input logic [15:0] bv);
    int     w;
    longint x, y, p, mask;
    w = wide ? 16 : 8;
    mask = (longint'(1) << w) - 1;
    x = longint'(av) & mask;
    y = longint'(bv) & mask;
    if (sgn && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
    if (sgn && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
    p = (x * y) & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  // Issue one operation. At iteration poke_at a stray start with operands
  // 1*1 is injected for one cycle. Returns product, cycles to done, busy count.
  task automatic run_op(input bit wide, input bit sgn,
                        input logic [15:0] av, input logic [15:0] bv,
                        input int poke_at,
                        output logic [31:0] res, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    res  = '0;
    if (wide) begin start16 = 1'b1; sg16 = sgn; a16 = av;      b16 = bv;      end
    else      begin start8  = 1'b1; sg8  = sgn; a8  = av[7:0]; b8  = bv[7:0]; end
    @(posedge clk); #1;
    start8  = 1'b0;
    start16 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == poke_at) begin
        if (wide) begin start16 = 1'b1; a16 = 16'd1; b16 = 16'd1; end
        else      begin start8  = 1'b1; a8  = 8'd1;  b8  = 8'd1;  end
      end else begin
        start8  = 1'b0;
        start16 = 1'b0;
      end
      if (wide ? busy16 : busy8) bcnt++;
      @(posedge clk); #1;
      if (wide ? done16 : done8) begin
        lat = k;
        res = wide ? c16 : {16'h0000, c8};
        break;
      end
    end
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic check_op(input string tag, input bit wide, input bit sgn,
                          input logic [15:0] av, input logic [15:0] bv,
                          input logic [31:0] exp, input int poke_at);
    logic [31:0] res;
    int          lat, bcnt;
    run_op(wide, sgn, av, bv, poke_at, res, lat, bcnt);
    check({tag, " latency"}, lat, wide ? 32'd18 : 32'd10);
    check({tag, " busy cycles"}, bcnt, wide ? 32'd17 : 32'd9);
    check({tag, " product"}, res, exp);
    check({tag, " idle after done"}, {31'd0, wide ? busy16 : busy8}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, " product held"}, wide ? c16 : {16'h0000, c8}, exp);
    check({tag, " done pulse ended"}, {31'd0, wide ? done16 : done8}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    bit          rs, rw;

    rst_n = 1'b0;
    start8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset busy8", {31'd0, busy8}, 32'd0);
    check("reset done8", {31'd0, done8}, 32'd0);
    check("reset c8", {16'h0, c8}, 32'd0);
    check("reset busy16", {31'd0, busy16}, 32'd0);
    check("reset c16", c16, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // No start: stays idle
    @(posedge clk); #1;
    check("idle without start", {31'd0, busy8}, 32'd0);

    // Directed 8-bit cases
    check_op("s -16*-16", 1'b0, 1'b1, 16'h00F0, 16'h00F0, 32'h0100, 0);
    check_op("s -75*32", 1'b0, 1'b1, 16'h00B5, 16'h0020, 32'hF6A0, 0);
    check_op("s 7*0", 1'b0, 1'b1, 16'h0007, 16'h0000, 32'h0000, 0);
    check_op("s -128*-128", 1'b0, 1'b1, 16'h0080, 16'h0080, 32'h4000, 0);
    check_op("u FF*FF", 1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'hFE01, 0);
    check_op("s FF*FF", 1'b0, 1'b1, 16'h00FF, 16'h00FF, 32'h0001, 0);

    // Start and operand changes while busy / in DONE are ignored
    check_op("poke while busy", 1'b0, 1'b1, 16'h0003, 16'h0005, 32'h000F, 3);
    check_op("poke in DONE", 1'b0, 1'b0, 16'h0012, 16'h0034, 32'h03A8, 10);
    check_op("after pokes 1*1", 1'b0, 1'b1, 16'h0001, 16'h0001, 32'h0001, 0);

    // Asynchronous reset in the middle of RUN
    start8 = 1'b1; sg8 = 1'b1; a8 = 8'd52; b8 = 8'd5;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid-run busy before reset", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy8}, 32'd0);
    check("abort done", {31'd0, done8}, 32'd0);
    check("abort c", {16'h0, c8}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("no done after abort", {31'd0, done8}, 32'd0);
    check("c still 0 after abort", {16'h0, c8}, 32'd0);
    check_op("s 52*5 after reset", 1'b0, 1'b1, 16'd52, 16'd5, 32'h0104, 0);

    // 16-bit instance
    check_op("w16 s 8000*8000", 1'b1, 1'b1, 16'h8000, 16'h8000, 32'h40000000, 0);
    check_op("w16 u FFFF*2", 1'b1, 1'b0, 16'hFFFF, 16'h0002, 32'h0001FFFE, 0);

    // Randomised operands and modes against the integer model
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      rw = (i % 3) == 2;
      if (!rw) begin
        ra[15:8] = 8'h00;
        rb[15:8] = 8'h00;
      end
      check_op($sformatf("rand%0d %s%0d", i, rs ? "s" : "u", rw ? 16 : 8),
               rw, rs, ra, rb, model(rw, rs, ra, rb), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised, multi-cycle radix-2 Booth multiplier.
- Successor to the fixed 8-bit combinational booth multiplier: width is a parameter, signed or unsigned mode is selected per operation, and a start/busy/done handshake replaces the combinational path.
- Iterates one Booth step per clock and holds the 2*WIDTH-bit product in a register.
- Sits beside the datapath as a shared low-area multiply resource.

Parameters:
- WIDTH, 8, operand width in bits (>= 2). Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while idle.
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when c is updated.
- c  output  2*WIDTH  product register.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy=0; done=0; c=0; internal registers cleared. Reset mid-operation aborts the operation. c stays 0 and no done is produced.
- Internal width N=WIDTH+1. Operands are extended to N bits: sign-extended if is_signed=1, zero-extended if is_signed=0. Both modes use the same Booth datapath, and iteration count is N in both modes.
- Because operands are extended from WIDTH bits, the multiplicand can never be -2^WIDTH. The accumulator A is N+1 bits, sign-extended, so it never overflows.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load M=ext(a), A=0, Q=ext(b), q_1=0, cnt=N.
  - Go to RUN; busy=1 next cycle.
  - start=0: remain in IDLE.
- RUN, once per cycle:
  - Examine {Q[0],q_1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> no add.
  - Then arithmetic shift right of {A,Q,q_1} by one (A MSB replicated).
  - cnt decrements. When cnt reaches 1 in the current cycle, the next state is DONE.
- DONE (one cycle):
  - c <= low 2*WIDTH bits of {A,Q}; done=1 for this cycle; busy=0.
  - Return to IDLE.
- Latency: start sampled at edge 0; busy high edges 1..N; c valid and done=1 after edge N+1, i.e. N+1 cycles start-to-done.
- Back-to-back: start may be asserted in the DONE cycle. It is ignored because the state is not IDLE. The earliest re-accept is the cycle after done.
- start asserted while busy/DONE: ignored. Operand changes during RUN have no effect.
- c holds its value between done pulses. c only changes in DONE or on reset.
- Result is exact for every operand pair in both modes; no saturation, no overflow flag.
- Unsigned result equals a*b modulo 2^(2W), which is exact.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Function cnt_width(WIDTH) = clog2(WIDTH+2) for sizing cnt.
  - Booth-code constants for {Q[0],q_1}.
- One sub-module booth_step:
  - Purely combinational.
  - Inputs: A, Q, q_1, M.
  - Outputs: next A, Q, q_1 after add/sub and arithmetic shift.
  - Parametrised on N.
- booth_mult_seq holds the FSM, counter, operand registers and c.

Test Plan:
- WIDTH=8, signed, a=-16 (0xF0), b=-16 -> done exactly 10 cycles after start; c=0x0100 (256); busy high 9 cycles.
- WIDTH=8, signed, a=-75 (0xB5), b=32 -> c=0xF6A0 (-2400). Then a=7, b=0 -> c=0x0000. Then a=-128, b=-128 -> c=0x4000.
- WIDTH=8, unsigned, a=0xFF, b=0xFF -> c=0xFE01. The same bits signed -> c=0x0001.
- Pulse start with new operands (a=1, b=1) while busy -> ignored; c and done timing unchanged for the first op. The next start after done gives c=0x0001.
- Drop rst_n at cycle 4 of RUN for a=52, b=5 -> busy=0, done=0, c=0 immediately (asynchronous). After release, a fresh start with the same operands gives c=0x0104 (260).
- WIDTH=16 instance, signed, a=0x8000, b=0x8000 -> c=0x40000000, done after 18 cycles. Unsigned 0xFFFF*0x0002 -> c=0x0001FFFE.
